// File: rtl/regfile_pkg.sv
// Shared register-file constants, the write-back queue entry type and the
// per-entry forwarding match used by the lookup path.
package regfile_pkg;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int NREG = 1 << AW;

  typedef struct packed {
    logic          swap;
    logic [AW-1:0] reg_a;
    logic [AW-1:0] reg_b;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
  } wb_entry_t;

  typedef struct packed {
    logic          hit;
    logic [DW-1:0] data;
  } lk_res_t;

  // reg_a is tested first so a swap with reg_a==reg_b yields data_b.
  function automatic lk_res_t lookup_entry(input wb_entry_t e, input logic [AW-1:0] r);
    lk_res_t res;
    res.hit  = 1'b0;
    res.data = '0;
    if (e.reg_a == r) begin
      res.hit  = 1'b1;
      res.data = e.swap ? e.data_b : e.data_a;
    end else if (e.swap && (e.reg_b == r)) begin
      res.hit  = 1'b1;
      res.data = e.data_a;
    end
    return res;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Circular write-back queue; every slot is exposed so the owner can run
// a forwarding search across all queued entries.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(wb_entry_t),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            wdata,
  output logic [W-1:0]            rdata,
  output logic [PW-1:0]           head,
  output logic [PW:0]             count,
  output logic [DEPTH-1:0][W-1:0] slots
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head_reg, tail_reg;
  logic [PW:0]   count_reg;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_reg] <= wdata;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign slots[gi] = mem[gi];
  end

  assign rdata = mem[head_reg];
  assign head  = head_reg;
  assign count = count_reg;
endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register write-back controller: queues single/swap writes, drains one per
// cycle when the register file allows, and forwards the youngest pending value.
module reg_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_swap,
  input  logic [AW-1:0] req_reg_a,
  input  logic [AW-1:0] req_reg_b,
  input  logic [DW-1:0] req_data_a,
  input  logic [DW-1:0] req_data_b,
  input  logic          wb_en,
  output logic          rf_wrt,
  output logic          rf_swp,
  output logic [AW-1:0] rf_reg_a,
  output logic [AW-1:0] rf_reg_b,
  output logic [DW-1:0] rf_data_a,
  output logic [DW-1:0] rf_data_b,
  input  logic [AW-1:0] lk_reg,
  output logic          lk_hit,
  output logic [DW-1:0] lk_data,
  output logic [PW:0]   pending,
  output logic          empty
);
  import regfile_pkg::*;

  localparam int EW = $bits(wb_entry_t);

  wb_entry_t                req_entry, head_entry, rf_entry;
  logic [EW-1:0]            head_raw;
  logic [DEPTH-1:0][EW-1:0] slots;
  logic [PW-1:0]            head;
  logic [PW:0]              count;
  logic                     push, pop;

  logic          rf_wrt_reg, rf_swp_reg;
  logic [AW-1:0] rf_reg_a_reg, rf_reg_b_reg;
  logic [DW-1:0] rf_data_a_reg, rf_data_b_reg;

  assign req_entry = '{swap: req_swap, reg_a: req_reg_a, reg_b: req_reg_b,
                       data_a: req_data_a, data_b: req_data_b};

  // Readiness comes from the registered count only, so a full queue refuses
  // a request even in a cycle where it also drains.
  assign req_ready = (count < (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign pending   = count;
  assign push      = req_valid && req_ready;
  assign pop       = !empty && wb_en;

  wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (req_entry),
    .rdata (head_raw),
    .head  (head),
    .count (count),
    .slots (slots)
  );

  assign head_entry = wb_entry_t'(head_raw);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wrt_reg    <= 1'b0;
      rf_swp_reg    <= 1'b0;
      rf_reg_a_reg  <= '0;
      rf_reg_b_reg  <= '0;
      rf_data_a_reg <= '0;
      rf_data_b_reg <= '0;
    end else if (pop) begin
      rf_wrt_reg    <= 1'b1;
      rf_swp_reg    <= head_entry.swap;
      rf_reg_a_reg  <= head_entry.reg_a;
      rf_reg_b_reg  <= head_entry.reg_b;
      rf_data_a_reg <= head_entry.data_a;
      rf_data_b_reg <= head_entry.data_b;
    end else begin
      rf_wrt_reg <= 1'b0;
      rf_swp_reg <= 1'b0;
    end
  end

  assign rf_wrt    = rf_wrt_reg;
  assign rf_swp    = rf_swp_reg;
  assign rf_reg_a  = rf_reg_a_reg;
  assign rf_reg_b  = rf_reg_b_reg;
  assign rf_data_a = rf_data_a_reg;
  assign rf_data_b = rf_data_b_reg;

  assign rf_entry = '{swap: rf_swp_reg, reg_a: rf_reg_a_reg, reg_b: rf_reg_b_reg,
                      data_a: rf_data_a_reg, data_b: rf_data_b_reg};

  // Results are indexed by age: 0 is the head (oldest queued entry).
  lk_res_t                 rf_res;
  lk_res_t [DEPTH-1:0]     age_res;
  logic    [DEPTH-1:0]     age_valid;

  assign rf_res = lookup_entry(rf_entry, lk_reg);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PW-1:0] idx;
    assign idx            = head + PW'(gi);
    assign age_valid[gi]  = ((PW+1)'(gi) < count);
    assign age_res[gi]    = lookup_entry(wb_entry_t'(slots[idx]), lk_reg);
  end

  // Walk oldest to youngest so the last match seen is the youngest write.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    if (rf_wrt_reg && rf_res.hit) begin
      lk_hit  = 1'b1;
      lk_data = rf_res.data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (age_valid[k] && age_res[k].hit) begin
        lk_hit  = 1'b1;
        lk_data = age_res[k].data;
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl: single/swap writes, back-pressure,
// forwarding priority, pointer wrap and asynchronous reset.
module tb_reg_writeback_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_swap = 1'b0;
  logic [3:0]  req_reg_a = '0, req_reg_b = '0;
  logic [15:0] req_data_a = '0, req_data_b = '0;
  logic        wb_en = 1'b0;
  logic        rf_wrt, rf_swp;
  logic [3:0]  rf_reg_a, rf_reg_b;
  logic [15:0] rf_data_a, rf_data_b;
  logic [3:0]  lk_reg = '0;
  logic        lk_hit;
  logic [15:0] lk_data;
  logic [2:0]  pending;
  logic        empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_writeback_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_swap(req_swap),
    .req_reg_a(req_reg_a), .req_reg_b(req_reg_b),
    .req_data_a(req_data_a), .req_data_b(req_data_b),
    .wb_en(wb_en),
    .rf_wrt(rf_wrt), .rf_swp(rf_swp), .rf_reg_a(rf_reg_a), .rf_reg_b(rf_reg_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .lk_reg(lk_reg), .lk_hit(lk_hit), .lk_data(lk_data),
    .pending(pending), .empty(empty)
  );

  always @(negedge clk) begin
    if (rf_wrt)
      $display("%0t WB swp=%0d reg_a=%0d reg_b=%0d data_a=%h data_b=%h",
               $time, rf_swp, rf_reg_a, rf_reg_b, rf_data_a, rf_data_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic sw, input logic [3:0] a, input logic [3:0] b,
                     input logic [15:0] da, input logic [15:0] db);
    req_valid  = 1'b1;
    req_swap   = sw;
    req_reg_a  = a;
    req_reg_b  = b;
    req_data_a = da;
    req_data_b = db;
  endtask

  task automatic lookup(input string tag, input logic [3:0] r,
                        input logic hit, input logic [15:0] data);
    lk_reg = r;
    #1;
    chk({tag, "_hit"}, 32'(lk_hit), 32'(hit));
    chk({tag, "_data"}, 32'(lk_data), 32'(data));
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_wrt", 32'(rf_wrt), 0);
    chk("rst_swp", 32'(rf_swp), 0);
    chk("rst_data_a", 32'(rf_data_a), 0);
    lookup("rst_lk", 4'd0, 1'b0, 16'h0);
    #11 rst = 1'b1;
    tick();

    // Single write with one-cycle latency
    wb_en = 1'b1;
    req(1'b0, 4'd3, 4'd9, 16'h1234, 16'h5555);
    tick();
    req_valid = 1'b0;
    chk("s1_pending", 32'(pending), 1);
    chk("s1_wrt_n", 32'(rf_wrt), 0);
    tick();
    chk("s1_wrt", 32'(rf_wrt), 1);
    chk("s1_swp", 32'(rf_swp), 0);
    chk("s1_reg_a", 32'(rf_reg_a), 3);
    chk("s1_data_a", 32'(rf_data_a), 32'h1234);
    chk("s1_reg_b", 32'(rf_reg_b), 9);
    chk("s1_data_b", 32'(rf_data_b), 32'h5555);
    chk("s1_empty", 32'(empty), 1);
    lookup("s1_lk_rf", 4'd3, 1'b1, 16'h1234);
    lookup("s1_lk_b", 4'd9, 1'b0, 16'h0);
    tick();
    chk("s1_wrt_off", 32'(rf_wrt), 0);
    chk("s1_hold", 32'(rf_data_a), 32'h1234);
    lookup("s1_lk_gone", 4'd3, 1'b0, 16'h0);

    // Five back-to-back requests into a held queue
    wb_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req(1'b0, (i == 0) ? 4'd0 : (i == 1) ? 4'd15 : 4'(i + 4), 4'd0,
          16'h1000 + 16'(i), 16'h0);
      #1;
      chk($sformatf("bb_ready%0d", i), 32'(req_ready), (i < 4) ? 1 : 0);
      tick();
      chk($sformatf("bb_pending%0d", i), 32'(pending), (i < 4) ? i + 1 : 4);
    end
    req_valid = 1'b0;
    chk("bb_full", 32'(req_ready), 0);
    lookup("bb_lk15", 4'd15, 1'b1, 16'h1001);
    lookup("bb_lk0", 4'd0, 1'b1, 16'h1000);
    lookup("bb_lk8", 4'd8, 1'b0, 16'h0);
    wb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("bb_wrt%0d", i), 32'(rf_wrt), 1);
      chk($sformatf("bb_reg%0d", i), 32'(rf_reg_a),
          (i == 0) ? 0 : (i == 1) ? 15 : i + 4);
      chk($sformatf("bb_data%0d", i), 32'(rf_data_a), 32'h1000 + i);
    end
    chk("bb_empty", 32'(empty), 1);
    tick();
    chk("bb_idle", 32'(rf_wrt), 0);

    // Youngest write wins
    wb_en = 1'b0;
    req(1'b0, 4'd5, 4'd0, 16'h0011, 16'h0);
    tick();
    req(1'b0, 4'd5, 4'd0, 16'h0022, 16'h0);
    tick();
    req_valid = 1'b0;
    lookup("yw_q", 4'd5, 1'b1, 16'h0022);
    wb_en = 1'b1;
    tick();
    chk("yw_rf_old", 32'(rf_data_a), 32'h0011);
    lookup("yw_mix", 4'd5, 1'b1, 16'h0022);
    tick();
    lookup("yw_rf", 4'd5, 1'b1, 16'h0022);
    tick();
    lookup("yw_none", 4'd5, 1'b0, 16'h0);

    // Swap semantics
    wb_en = 1'b0;
    req(1'b1, 4'd1, 4'd2, 16'hAAAA, 16'hBBBB);
    tick();
    req(1'b1, 4'd7, 4'd7, 16'hCCCC, 16'hDDDD);
    tick();
    req_valid = 1'b0;
    lookup("sw_a", 4'd1, 1'b1, 16'hBBBB);
    lookup("sw_b", 4'd2, 1'b1, 16'hAAAA);
    lookup("sw_same", 4'd7, 1'b1, 16'hDDDD);
    wb_en = 1'b1;
    tick();
    chk("sw_swp", 32'(rf_swp), 1);
    chk("sw_reg_a", 32'(rf_reg_a), 1);
    chk("sw_reg_b", 32'(rf_reg_b), 2);
    chk("sw_data_a", 32'(rf_data_a), 32'hAAAA);
    chk("sw_data_b", 32'(rf_data_b), 32'hBBBB);
    lookup("sw_rf_b", 4'd2, 1'b1, 16'hAAAA);
    tick();
    chk("sw2_swp", 32'(rf_swp), 1);
    chk("sw2_reg_a", 32'(rf_reg_a), 7);
    tick();
    chk("sw_idle_wrt", 32'(rf_wrt), 0);
    chk("sw_idle_swp", 32'(rf_swp), 0);

    // Full queue while draining, plus pointer wrap
    wb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 4'(10 + i), 4'd0, 16'h2000 + 16'(i), 16'h0);
      tick();
    end
    wb_en = 1'b1;
    req(1'b0, 4'd14, 4'd0, 16'h2EEE, 16'h0);
    #1;
    chk("fd_ready0", 32'(req_ready), 0);
    tick();
    chk("fd_pending0", 32'(pending), 3);
    chk("fd_reg0", 32'(rf_reg_a), 10);
    chk("fd_ready1", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    chk("fd_pending1", 32'(pending), 3);
    chk("fd_reg1", 32'(rf_reg_a), 11);
    tick();
    chk("fd_reg2", 32'(rf_reg_a), 12);
    tick();
    chk("fd_reg3", 32'(rf_reg_a), 13);
    tick();
    chk("fd_reg4", 32'(rf_reg_a), 14);
    chk("fd_data4", 32'(rf_data_a), 32'h2EEE);
    chk("fd_empty", 32'(empty), 1);

    // Asynchronous reset mid-operation
    wb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 4'(1 + i), 4'd0, 16'h3000 + 16'(i), 16'h0);
      tick();
    end
    req_valid = 1'b0;
    wb_en = 1'b1;
    tick();
    chk("ar_pre_pending", 32'(pending), 3);
    chk("ar_pre_wrt", 32'(rf_wrt), 1);
    rst = 1'b0;
    #1;
    chk("ar_wrt", 32'(rf_wrt), 0);
    chk("ar_pending", 32'(pending), 0);
    chk("ar_data_a", 32'(rf_data_a), 0);
    lookup("ar_lk", 4'd2, 1'b0, 16'h0);
    tick();
    #4 rst = 1'b1;
    tick();
    chk("ar_post_wrt", 32'(rf_wrt), 0);
    chk("ar_post_pending", 32'(pending), 0);
    tick();
    chk("ar_post2_wrt", 32'(rf_wrt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_writeback_ctrl.md
REG_WRITEBACK_CTRL -- requirements
Module: reg_writeback_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queued write entries (power of 2, at least 2).
REQ-002 Parameter DW, default 16, SHALL set the data width; AW, default 4, SHALL set the register address width.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req_valid  input  1: a write request is presented; req_ready  output  1: the request can be accepted.
REQ-006 req_swap  input  1: the request is a swap (two-register write), not a single write.
REQ-007 req_reg_a, req_reg_b  input  AW: target registers; req_data_a, req_data_b  input  DW: write data.
REQ-008 wb_en  input  1: the register file may accept a write this cycle (low = hold).
REQ-009 rf_wrt, rf_swp  output  1: write and swap strobes toward the register file.
REQ-010 rf_reg_a, rf_reg_b  output  AW and rf_data_a, rf_data_b  output  DW: write address and data toward the register file.
REQ-011 lk_reg  input  AW: lookup register; lk_hit  output  1 and lk_data  output  DW: forwarding result.
REQ-012 pending  output  log2(DEPTH)+1: number of queued entries; empty  output  1: pending==0.

Function
- REQ-013 Accept: on posedge with req_valid && req_ready, the entry {swap, reg_a, reg_b, data_a, data_b} SHALL be written at the tail.
- REQ-014 req_ready SHALL equal (pending < DEPTH), derived only from registered state; a full queue SHALL NOT accept, even while draining.
- REQ-015 Drain: on posedge with !empty && wb_en, the head entry SHALL be popped and loaded into the rf_* registers with rf_wrt=1 and rf_swp=entry.swap.
- REQ-016 On any posedge that does not pop, rf_wrt and rf_swp SHALL be 0; rf_reg/rf_data SHALL hold their previous values.
- REQ-017 Single write (rf_swp=0): only rf_reg_a/rf_data_a are meaningful; rf_reg_b and rf_data_b SHALL carry the entry fields unchanged.
- REQ-018 Swap semantics: reg_a receives data_b and reg_b receives data_a; if reg_a==reg_b, that register receives data_b.
- REQ-019 Latency: a request accepted at edge N SHALL appear on rf_* no earlier than edge N+1, in acceptance order, one entry per cycle.
- REQ-020 Simultaneous accept and pop SHALL leave pending unchanged; pointers SHALL wrap modulo DEPTH.
- REQ-021 Lookup (combinational) SHALL search all queued entries plus the rf_* stage while rf_wrt=1; the youngest matching write wins; the rf_* stage is the oldest.
- REQ-022 A lookup match SHALL include reg_a of any entry, and reg_b of swap entries only; returned data SHALL follow REQ-018.
- REQ-023 With no match, lk_hit SHALL be 0 and lk_data SHALL be 0.
- REQ-024 The block SHALL NOT treat any register number specially (R0 and R15 are ordinary targets).

Reset
- REQ-025 While rst=0: pointers=0, pending=0, empty=1, req_ready=1, rf_wrt=0, rf_swp=0, rf_reg_a/b=0, rf_data_a/b=0, lk_hit=0, lk_data=0.
- REQ-026 Reset asserted mid-operation SHALL discard all queued entries and any in-flight rf_* strobe immediately; no write SHALL issue on the first edge after release.

Structure
- REQ-027 The shared package regfile_pkg SHALL hold the DW/AW/NREG constants and the typedef wb_entry_t {swap, reg_a, reg_b, data_a, data_b}.
- REQ-028 The storage and pointers SHALL be one sub-module, wb_fifo; the lookup priority logic and rf_* output stage SHALL remain in the top.

Verification
- REQ-029 Single write reg 3 = 0x1234, wb_en=1 -> next edge rf_wrt=1, rf_reg_a=3, rf_data_a=0x1234; the following edge rf_wrt=0.
- REQ-030 wb_en=0, 5 back-to-back requests -> 4 accepted, req_ready=0, pending=4; wb_en=1 -> 4 writes in order, empty=1.
- REQ-031 Queue write r5=0x0011, then r5=0x0022, wb_en=0, lk_reg=5 -> lk_hit=1, lk_data=0x0022.
- REQ-032 Swap a=1, b=2, data_a=0xAAAA, data_b=0xBBBB -> rf_swp=1; lk_reg=1 gives 0xBBBB, lk_reg=2 gives 0xAAAA; if a=b=7, lk_reg=7 gives 0xBBBB.
- REQ-033 Full queue with wb_en=1 and req_valid=1 -> req_ready=0 that cycle, one pop, pending=3, then accept.
- REQ-034 rst pulsed low with pending=3 and rf_wrt=1 -> immediately rf_wrt=0, pending=0, lk_hit=0; no writes after release.
